hex7seg_capture: RTL and testbench
==================================

// Module: hex7seg_capture
// PURPOSE
//  Reader side of the board's active-low 7-segment hex display path. Samples a multiplexed
//  display bus (shared segment lines plus one-hot digit strobes) and filters glitches.
//  Converts each stable segment pattern back to its hex nibble. Assembles a full
//  NDIG-digit word and hands it out on a valid/ready interface. Used for display loopback
//  checking and for reading MIPS register-file values shown on the HEX displays.
// PARAMETERS
//  NDIG        8   digits per frame; word width = 4*NDIG; strobe bit k -> oWORD[4k+3:4k]
//  STABLE_CYC  4   consecutive identical cycles required before a digit is captured (>=1)
// PORTS
//  iCLK      in   1        system clock, rising edge
//  iRST      in   1        asynchronous reset, active-high
//  iSEG      in   7        segment lines, active-low, bit6=g ... bit0=a
//  iDIG_SEL  in   NDIG     digit strobe, active-high; valid only when exactly one-hot
//  iRDY      in   1        consumer ready
//  oWORD     out  4*NDIG   assembled hex word
//  oVALID    out  1        oWORD/oERR valid; held until accepted
//  oERR      out  1        at least one digit in this word had an unrecognised pattern
// BEHAVIOUR
//  Reset (async, iRST=1): oWORD=0, oVALID=0, oERR=0, capture mask=0, stable count=0,
//   previous-sample regs=0, state=SCAN. Release is synchronous to iCLK.
//  Pattern table (iSEG -> nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8
//   18->9 08->A 03->B 46->C 21->D 06->E 0E->F (hex). Any other pattern: nibble=0, error.
//  Stability: registered copy of {iDIG_SEL,iSEG}. If current == previous and iDIG_SEL is
//   one-hot, count saturates at STABLE_CYC; otherwise count=0. Count starts at 0 on the
//   first cycle of a new pair. Capture fires in the single cycle where count == STABLE_CYC-1
//   and input still matches, i.e. after STABLE_CYC identical cycles. Capture fires once per dwell.
//  Capture (state SCAN only): if digit k's mask bit is 0, write nibble into oWORD[4k+3:4k],
//   set mask bit k, and OR the pattern's error into oERR. If the mask bit is already 1,
//   ignore the capture; the first capture wins.
//  Zero, multi-hot, or changing strobe: no capture, count=0.
//  FSM:
//   SCAN -> HOLD on the cycle after mask becomes all-ones; oVALID=1 from that cycle.
//   HOLD: oVALID=1; oWORD/oERR frozen; all bus activity ignored, but stability regs keep tracking.
//   HOLD with iRDY=1 sampled at an edge -> transfer. Next cycle: oVALID=0, mask=0, oERR=0,
//    oWORD keeps old value, state=SCAN.
//   iRDY high while oVALID=0 has no effect. oVALID never drops without iRDY except on reset.
//  Latency: final digit stable for STABLE_CYC cycles -> capture at edge N -> oVALID=1 at N+1.
//  Reset mid-frame or mid-HOLD: partial mask and word discarded; scanning restarts from zero.
//  Width rules: count width = $clog2(STABLE_CYC+1). Strobe index comes from a one-hot-to-binary
//   function of width $clog2(NDIG), with NDIG=1 treated as width 1.
// STRUCTURE
//  Shared package/include (hex7seg_defs): 16-entry active-low pattern constants SEG_HEX_0..F,
//   shared with the display encoder so both ends use one table; FSM state encodings SCAN/HOLD.
//  One sub-module: seg7_to_hex (combinational iSEG[6:0] -> {nib[3:0], bad}) via case on the
//   package constants. Stability counter, mask, word register and FSM stay in the top module.
// TESTING
//  1 Drive digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each for 6 cycles, STABLE_CYC=4 ->
//    oVALID=1 with oWORD=32'h87654321, oERR=0; exactly 1 cycle after digit 7's capture.
//  2 Hold iRDY=0 for 20 cycles after oVALID, then pulse it 1 cycle. Change the bus meanwhile ->
//    oWORD stays stable; oVALID=0 the next cycle; the following frame 0xFEDCBA90 is captured cleanly.
//  3 Toggle iSEG between 40 and 79 every 2 cycles on digit 3 -> no capture. Then hold 79 for
//    4 cycles -> nibble 1 at [15:12].
//  4 Drive digit 5 with pattern 7F (blank), other digits valid -> oERR=1, oWORD[23:20]=0;
//    after the handshake, oERR=0 for the next clean frame.
//  5 Drive multi-hot strobe 8'h03 with a stable pattern for 10 cycles -> mask unchanged.
//    Revisit digit 2 with a new value after its capture -> first value retained.
//  6 Assert iRST with 5 of 8 digits captured, and again during HOLD -> all outputs 0 immediately.
//    Then a full frame captures correctly; also run NDIG=1, STABLE_CYC=1 (capture after 1 cycle).

Source files
------------

// File: rtl/hex7seg_defs.sv
// Shared definitions for the active-low 7-segment hex path.
// The pattern table here is used by both the display encoder and the capture side.
package hex7seg_defs;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h18;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Encoder direction of the table, kept next to the constants so both ends stay in step.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder from an active-low segment pattern back to its hex nibble.
// Unrecognised patterns decode to zero and raise bad.
module seg7_to_hex
    import hex7seg_defs::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       bad
);

    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
        case (seg)
            SEG_HEX_0: nib = 4'h0;
            SEG_HEX_1: nib = 4'h1;
            SEG_HEX_2: nib = 4'h2;
            SEG_HEX_3: nib = 4'h3;
            SEG_HEX_4: nib = 4'h4;
            SEG_HEX_5: nib = 4'h5;
            SEG_HEX_6: nib = 4'h6;
            SEG_HEX_7: nib = 4'h7;
            SEG_HEX_8: nib = 4'h8;
            SEG_HEX_9: nib = 4'h9;
            SEG_HEX_A: nib = 4'hA;
            SEG_HEX_B: nib = 4'hB;
            SEG_HEX_C: nib = 4'hC;
            SEG_HEX_D: nib = 4'hD;
            SEG_HEX_E: nib = 4'hE;
            SEG_HEX_F: nib = 4'hF;
            default:   bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/hex7seg_capture.sv
// Reads back a multiplexed active-low hex display: debounces each digit, decodes it,
// assembles an NDIG-digit word and offers it on a valid/ready handshake.
module hex7seg_capture
    import hex7seg_defs::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [6:0]          iSEG,
    input  logic [NDIG-1:0]     iDIG_SEL,
    input  logic                iRDY,
    output logic [4*NDIG-1:0]   oWORD,
    output logic                oVALID,
    output logic                oERR
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYC - 1);

    function automatic logic is_onehot(input logic [NDIG-1:0] v);
        return (v != '0) && ((v & (v - NDIG'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_bin(input logic [NDIG-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (v[k]) begin
                idx = idx | IDX_W'(k);
            end
        end
        return idx;
    endfunction

    logic [NDIG-1:0]   prev_sel_q, prev_sel_d;
    logic [6:0]        prev_seg_q, prev_seg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] word_q, word_d;
    logic              err_q, err_d;
    state_e            state_q, state_d;

    logic              stable;
    logic              fire;
    logic [IDX_W-1:0]  sel_idx;
    logic [3:0]        dec_nib;
    logic              dec_bad;

    seg7_to_hex u_dec (
        .seg (iSEG),
        .nib (dec_nib),
        .bad (dec_bad)
    );

    // The count saturates so a long dwell on one digit produces exactly one capture.
    always_comb begin
        prev_sel_d = iDIG_SEL;
        prev_seg_d = iSEG;
        stable     = (iDIG_SEL == prev_sel_q) && (iSEG == prev_seg_q) && is_onehot(iDIG_SEL);
        fire       = stable && (cnt_q == CNT_FIRE);
        sel_idx    = onehot_to_bin(iDIG_SEL);
        cnt_d      = '0;
        if (stable) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            SCAN: begin
                if (mask_q == '1) begin
                    state_d = HOLD;
                end
                // First capture per digit wins; later revisits in the same frame are ignored.
                if (fire) begin
                    for (int k = 0; k < NDIG; k++) begin
                        if ((sel_idx == IDX_W'(k)) && !mask_q[k]) begin
                            word_d[4*k +: 4] = dec_nib;
                            mask_d[k]        = 1'b1;
                            err_d            = err_q | dec_bad;
                        end
                    end
                end
            end
            HOLD: begin
                if (iRDY) begin
                    state_d = SCAN;
                    mask_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            prev_sel_q <= '0;
            prev_seg_q <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            state_q    <= SCAN;
        end else begin
            prev_sel_q <= prev_sel_d;
            prev_seg_q <= prev_seg_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            word_q     <= word_d;
            err_q      <= err_d;
            state_q    <= state_d;
        end
    end

    assign oWORD  = word_q;
    assign oVALID = (state_q == HOLD);
    assign oERR   = err_q;

endmodule

// File: tb/tb_hex7seg_capture.sv
// Directed self-checking bench for hex7seg_capture (8-digit/4-cycle and 1-digit/1-cycle builds).
`timescale 1ns/1ps
module tb_hex7seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [7:0]  sel;
    logic        rdy;
    logic [31:0] word;
    logic        valid;
    logic        err;

    logic [6:0]  seg1;
    logic        sel1;
    logic        rdy1;
    logic [3:0]  word1;
    logic        valid1;
    logic        err1;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    hex7seg_capture #(.NDIG(8), .STABLE_CYC(4)) u_dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iSEG     (seg),
        .iDIG_SEL (sel),
        .iRDY     (rdy),
        .oWORD    (word),
        .oVALID   (valid),
        .oERR     (err)
    );

    hex7seg_capture #(.NDIG(1), .STABLE_CYC(1)) u_dut1 (
        .iCLK     (clk),
        .iRST     (rst),
        .iSEG     (seg1),
        .iDIG_SEL (sel1),
        .iRDY     (rdy1),
        .oWORD    (word1),
        .oVALID   (valid1),
        .oERR     (err1)
    );

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] s, input logic [7:0] d, input int ncyc);
        seg = s;
        sel = d;
        repeat (ncyc) tick();
    endtask

    task automatic showDigit(input int k, input logic [3:0] n);
        applyStimulus(hexSeg(n), 8'(1 << k), 6);
    endtask

    task automatic sendFrame(input logic [31:0] w);
        for (int k = 0; k < 8; k++) begin
            showDigit(k, w[4*k +: 4]);
        end
    endtask

    task automatic handshake();
        seg = 7'h7F;
        sel = 8'h00;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic [31:0] w, input logic e);
        checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
        checkOutput({tag, "_word"}, word, w);
        checkOutput({tag, "_err"}, 32'(err), 32'(e));
    endtask

    initial begin
        rst  = 1'b1;
        seg  = 7'h00;
        sel  = 8'h00;
        rdy  = 1'b0;
        seg1 = 7'h00;
        sel1 = 1'b0;
        rdy1 = 1'b0;
        repeat (2) tick();
        checkOutput("rst_word", word, 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_valid1", 32'(valid1), 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: basic frame and one-cycle valid latency after the last capture
        for (int k = 0; k < 7; k++) begin
            showDigit(k, 4'(k + 1));
        end
        applyStimulus(hexSeg(4'h8), 8'h80, 5);
        checkOutput("t1_valid_at_capture", 32'(valid), 32'd0);
        tick();
        checkFrame("t1", 32'h87654321, 1'b0);

        // Test 2: bus activity during HOLD is ignored, then handshake
        for (int d = 0; d < 4; d++) begin
            applyStimulus(hexSeg(4'hE), 8'(1 << d), 5);
        end
        checkFrame("t2_hold", 32'h87654321, 1'b0);
        handshake();
        checkOutput("t2_valid_drop", 32'(valid), 32'd0);
        checkOutput("t2_word_kept", word, 32'h87654321);
        sendFrame(32'hFEDCBA90);
        checkFrame("t2_next", 32'hFEDCBA90, 1'b0);
        handshake();

        // Test 3: a toggling digit is never captured until it settles
        showDigit(0, 4'h5);
        showDigit(1, 4'h6);
        showDigit(2, 4'h7);
        for (int r = 0; r < 5; r++) begin
            applyStimulus(hexSeg((r % 2 == 1) ? 4'h1 : 4'h0), 8'h08, 2);
        end
        applyStimulus(hexSeg(4'h1), 8'h08, 5);
        showDigit(4, 4'h2);
        showDigit(5, 4'h3);
        showDigit(6, 4'h4);
        showDigit(7, 4'h8);
        checkFrame("t3", 32'h84321765, 1'b0);
        checkOutput("t3_nib3", 32'(word[15:12]), 32'h1);
        handshake();

        // Test 4: blank pattern flags an error; error clears for the next frame
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                applyStimulus(7'h7F, 8'h20, 6);
            end else begin
                showDigit(k, 4'(k + 1));
            end
        end
        checkFrame("t4_bad", 32'h87054321, 1'b1);
        checkOutput("t4_nib5", 32'(word[23:20]), 32'h0);
        handshake();
        checkOutput("t4_err_clear", 32'(err), 32'd0);
        sendFrame(32'h12345678);
        checkFrame("t4_clean", 32'h12345678, 1'b0);
        handshake();

        // Test 5: multi-hot strobe ignored; a revisited digit keeps its first value
        applyStimulus(hexSeg(4'h8), 8'h03, 10);
        showDigit(2, 4'h3);
        showDigit(2, 4'hC);
        showDigit(3, 4'h4);
        showDigit(4, 4'h5);
        showDigit(5, 4'h6);
        showDigit(6, 4'h7);
        showDigit(7, 4'h9);
        checkOutput("t5_not_full", 32'(valid), 32'd0);
        showDigit(0, 4'hA);
        showDigit(1, 4'hB);
        checkFrame("t5", 32'h976543BA, 1'b0);
        handshake();

        // Test 6: reset mid-frame and during HOLD
        for (int k = 0; k < 5; k++) begin
            showDigit(k, 4'hF);
        end
        seg = 7'h7F;
        sel = 8'h00;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_word", word, 32'h0);
        checkOutput("t6_rst_valid", 32'(valid), 32'd0);
        tick();
        rst = 1'b0;
        showDigit(5, 4'h6);
        showDigit(6, 4'h7);
        showDigit(7, 4'h8);
        checkOutput("t6_partial_discarded", 32'(valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            showDigit(k, 4'(k + 1));
        end
        applyStimulus(7'h7F, 8'h10, 6);
        checkFrame("t6_after_rst", 32'h87604321, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("t6_hold_rst_word", word, 32'h0);
        checkOutput("t6_hold_rst_valid", 32'(valid), 32'd0);
        checkOutput("t6_hold_rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        seg = 7'h7F;
        sel = 8'h00;
        tick();
        sendFrame(32'h0F1E2D3C);
        checkFrame("t6_full", 32'h0F1E2D3C, 1'b0);
        handshake();

        // Single-digit build with a one-cycle stability window
        seg1 = hexSeg(4'h5);
        sel1 = 1'b1;
        tick();
        checkOutput("n1_first_cycle", 32'(valid1), 32'd0);
        tick();
        checkOutput("n1_capture_cycle", 32'(valid1), 32'd0);
        tick();
        checkOutput("n1_valid", 32'(valid1), 32'd1);
        checkOutput("n1_word", 32'(word1), 32'h5);
        checkOutput("n1_err", 32'(err1), 32'd0);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        checkOutput("n1_valid_drop", 32'(valid1), 32'd0);
        repeat (3) tick();
        checkOutput("n1_once_per_dwell", 32'(valid1), 32'd0);
        seg1 = hexSeg(4'hA);
        repeat (3) tick();
        checkOutput("n1_second_valid", 32'(valid1), 32'd1);
        checkOutput("n1_second_word", 32'(word1), 32'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
